// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: accepts a WIDTH-bit word on a valid/ready
// handshake and shifts it out one bit per shift_en strobe, with zero-gap reload.
module piso_tx #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             shift_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic             ser_out_q, ser_out_d;
  logic             ser_valid_q, ser_valid_d;
  logic             ser_last_q, ser_last_d;
  logic             accept_s;

  function automatic logic first_bit(input logic [WIDTH-1:0] word);
    if (MSB_FIRST) begin
      first_bit = word[WIDTH-1];
    end else begin
      first_bit = word[0];
    end
  endfunction

  // Ready is open in IDLE, or on the last-bit strobe so the next word follows with no gap.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      IDLE:    in_ready = ~reset;
      SHIFT:   in_ready = ~reset & shift_en & (cnt_q == LAST_CNT);
      default: in_ready = 1'b0;
    endcase
    accept_s = in_valid & in_ready;
  end

  // Next-state and next-output computation for the transmit sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sreg_d      = sreg_q;
    ser_out_d   = ser_out_q;
    ser_valid_d = ser_valid_q;
    ser_last_d  = ser_last_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d     = SHIFT;
          cnt_d       = {CW{1'b0}};
          sreg_d      = data_in;
          ser_out_d   = first_bit(data_in);
          ser_valid_d = 1'b1;
          ser_last_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        if (shift_en && (cnt_q == LAST_CNT)) begin
          if (accept_s) begin
            state_d     = SHIFT;
            cnt_d       = {CW{1'b0}};
            sreg_d      = data_in;
            ser_out_d   = first_bit(data_in);
            ser_valid_d = 1'b1;
            ser_last_d  = 1'b0;
          end else begin
            state_d     = IDLE;
            cnt_d       = {CW{1'b0}};
            sreg_d      = {WIDTH{1'b0}};
            ser_out_d   = 1'b0;
            ser_valid_d = 1'b0;
            ser_last_d  = 1'b0;
          end
        end else if (shift_en) begin
          cnt_d      = cnt_q + CW'(1);
          ser_last_d = (cnt_d == LAST_CNT);
          // The register keeps the remaining bits aligned so the next bit sits beside the sent one.
          if (MSB_FIRST) begin
            sreg_d    = sreg_q << 1;
            ser_out_d = sreg_q[WIDTH-2];
          end else begin
            sreg_d    = sreg_q >> 1;
            ser_out_d = sreg_q[1];
          end
        end else begin
          state_d = SHIFT;
        end
      end
      default: begin
        state_d     = IDLE;
        cnt_d       = {CW{1'b0}};
        sreg_d      = {WIDTH{1'b0}};
        ser_out_d   = 1'b0;
        ser_valid_d = 1'b0;
        ser_last_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset wins over any accept or strobe in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= {CW{1'b0}};
      sreg_q      <= {WIDTH{1'b0}};
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sreg_q      <= sreg_d;
      ser_out_q   <= ser_out_d;
      ser_valid_q <= ser_valid_d;
      ser_last_q  <= ser_last_d;
    end
  end

  assign ser_out   = ser_out_q;
  assign ser_valid = ser_valid_q;
  assign ser_last  = ser_last_q;

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: MSB-first and LSB-first instances share stimulus and are
// compared each cycle against a queue-of-bits reference model.
module tb_piso_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       in_valid;
  logic       shift_en;
  logic       rdy_m, out_m, vld_m, lst_m;
  logic       rdy_l, out_l, vld_l, lst_l;

  int checks = 0;
  int errors = 0;
  int nv = 0;
  int nl = 0;

  // Pending bits still to appear on the serial line, front = currently shown.
  logic q_msb[$];
  logic q_lsb[$];
  logic q_last[$];

  always #5 clk = ~clk;

  piso_tx #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .data_in(data_in), .in_valid(in_valid),
    .in_ready(rdy_m), .shift_en(shift_en), .ser_out(out_m),
    .ser_valid(vld_m), .ser_last(lst_m)
  );

  piso_tx #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .data_in(data_in), .in_valid(in_valid),
    .in_ready(rdy_l), .shift_en(shift_en), .ser_out(out_l),
    .ser_valid(vld_l), .ser_last(lst_l)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic v, input logic [7:0] d, input logic se);
    logic exp_rdy, acc, ev;
    reset = r; in_valid = v; data_in = d; shift_en = se;
    #1;
    exp_rdy = !r && ((q_msb.size() == 0) || (q_msb.size() == 1 && se));
    chk("in_ready_msb", {31'd0, rdy_m}, {31'd0, exp_rdy});
    chk("in_ready_lsb", {31'd0, rdy_l}, {31'd0, exp_rdy});
    acc = v && exp_rdy;
    @(posedge clk);
    if (r) begin
      q_msb.delete(); q_lsb.delete(); q_last.delete();
    end else begin
      if (q_msb.size() > 0 && se) begin
        void'(q_msb.pop_front()); void'(q_lsb.pop_front()); void'(q_last.pop_front());
      end
      if (acc) begin
        for (int i = 0; i < 8; i++) begin
          q_msb.push_back(d[7-i]);
          q_lsb.push_back(d[i]);
          q_last.push_back(i == 7);
        end
      end
    end
    #1;
    ev = (q_msb.size() > 0);
    chk("ser_valid_msb", {31'd0, vld_m}, {31'd0, ev});
    chk("ser_valid_lsb", {31'd0, vld_l}, {31'd0, ev});
    chk("ser_out_msb", {31'd0, out_m}, {31'd0, ev ? q_msb[0] : 1'b0});
    chk("ser_out_lsb", {31'd0, out_l}, {31'd0, ev ? q_lsb[0] : 1'b0});
    chk("ser_last_msb", {31'd0, lst_m}, {31'd0, ev ? q_last[0] : 1'b0});
    chk("ser_last_lsb", {31'd0, lst_l}, {31'd0, ev ? q_last[0] : 1'b0});
    if (vld_m) nv++;
    if (lst_m) nl++;
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; data_in = 8'h00; shift_en = 1'b0;

    // Reset with in_valid asserted: must stay not-ready and silent.
    cyc(1'b1, 1'b1, 8'hA5, 1'b1);
    cyc(1'b1, 1'b1, 8'hA5, 1'b1);

    // Single frame 0xA5, both bit orders.
    nv = 0; nl = 0;
    cyc(1'b0, 1'b1, 8'hA5, 1'b1);
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b0, 8'($urandom), 1'b1);
    chk("a5_valid_cycles", nv, 32'd8);
    chk("a5_last_cycles", nl, 32'd1);

    // Slow bit rate: strobe every 4th cycle, 0x81.
    nv = 0; nl = 0;
    cyc(1'b0, 1'b1, 8'h81, 1'b0);
    for (int k = 0; k < 40; k++) cyc(1'b0, 1'b0, 8'($urandom), (k % 4) == 3);
    chk("slow_valid_cycles", nv, 32'd32);
    chk("slow_last_cycles", nl, 32'd4);

    // Back-to-back 0xF0 then 0x0F with in_valid held.
    nv = 0; nl = 0;
    cyc(1'b0, 1'b1, 8'hF0, 1'b1);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 8'h0F, 1'b1);
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("b2b_valid_cycles", nv, 32'd16);
    chk("b2b_last_cycles", nl, 32'd2);

    // Reset on the third bit of 0xFF, then a clean 0x01 frame.
    cyc(1'b0, 1'b1, 8'hFF, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1'b0, 1'b0, 8'h00, 1'b1);
    cyc(1'b1, 1'b1, 8'h55, 1'b1);
    nv = 0; nl = 0;
    cyc(1'b0, 1'b1, 8'h01, 1'b1);
    for (int i = 0; i < 9; i++) cyc(1'b0, 1'b0, 8'h00, 1'b1);
    chk("post_reset_valid_cycles", nv, 32'd8);
    chk("post_reset_last_cycles", nl, 32'd1);

    // 0x3C with data_in toggling and in_valid high while not ready.
    cyc(1'b0, 1'b1, 8'h3C, 1'b1);
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 8'($urandom), 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 8'h00, 1'b1);

    // Randomized traffic with irregular strobes and occasional reset.
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 59) == 0, 1'($urandom), 8'($urandom), $urandom_range(0, 3) != 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
